add_bias_kernel: RTL and testbench



---
 rtl/add_bias_pkg.sv | 13 +
 rtl/add_bias_pipe.sv | 57 +++++
 rtl/add_bias_kernel.sv | 123 ++++++++++++
 tb/tb_add_bias_kernel.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/add_bias_pkg.sv
// Shared types and constants for the add_bias kernel and its write pipeline.
package add_bias_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/add_bias_pipe.sv
// Two-stage write pipeline: stage 1 tracks read-data validity, stage 2 registers
// the biased result together with its write index.
module add_bias_pipe
  import add_bias_pkg::*;
#(
  parameter int ADDR_BITS = 6
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 rd_issue,
  input  logic [DATA_W-1:0]    rd_data,
  input  logic [DATA_W-1:0]    bias,
  input  logic [ADDR_BITS-1:0] wr_addr,
  output logic                 v1,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr_q,
  output logic [DATA_W-1:0]    wr_data
);

  logic                 v1_r;
  logic                 wr_valid_r;
  logic [ADDR_BITS-1:0] wr_addr_r;
  logic [DATA_W-1:0]    wr_data_r;

  // Stage 1: high in the cycle the memory returns data for last cycle's read.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1_r <= 1'b0;
    end else begin
      v1_r <= rd_issue;
    end
  end

  // Stage 2: registered write strobe, index and sum (carry out discarded).
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= {ADDR_BITS{1'b0}};
      wr_data_r  <= {DATA_W{1'b0}};
    end else begin
      wr_valid_r <= v1_r;
      if (v1_r) begin
        wr_addr_r <= wr_addr;
        wr_data_r <= rd_data + bias;
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
    end
  end

  assign v1        = v1_r;
  assign wr_valid  = wr_valid_r;
  assign wr_addr_q = wr_addr_r;
  assign wr_data   = wr_data_r;

endmodule

// File: rtl/add_bias_kernel.sv
// ap_ctrl_hs kernel: out_r[i] = in_r[i] + bias for i < min(len, depth), pipelined at II=1.
module add_bias_kernel
  import add_bias_pkg::*;
#(
  parameter int ADDR_BITS = 6
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [ADDR_BITS:0]   len,
  input  logic [DATA_W-1:0]    bias,
  output logic [ADDR_BITS-1:0] in_r_address0,
  output logic                 in_r_ce0,
  input  logic [DATA_W-1:0]    in_r_q0,
  output logic [ADDR_BITS-1:0] out_r_address0,
  output logic                 out_r_ce0,
  output logic                 out_r_we0,
  output logic [DATA_W-1:0]    out_r_d0
);

  localparam logic [ADDR_BITS:0]   DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   LEN_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] IDX_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_s;
  logic [ADDR_BITS:0]   len_q_r;
  logic [DATA_W-1:0]    bias_q_r;
  logic [ADDR_BITS-1:0] rd_idx_r;
  logic [ADDR_BITS-1:0] wr_idx_r;
  logic                 rd_issue_s;
  logic                 last_rd_s;
  logic                 accept_s;
  logic                 v1_s;
  logic                 wr_valid_s;

  assign accept_s   = (state_r == IDLE) && ap_start;
  assign rd_issue_s = (state_r == RUN);
  assign last_rd_s  = rd_issue_s && ({1'b0, rd_idx_r} == (len_q_r - LEN_ONE));

  // Next-state logic; DRAIN ends once the final write is on the port.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          state_s = (len == {(ADDR_BITS+1){1'b0}}) ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_rd_s) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (!v1_s && wr_valid_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, run parameters (sampled only on accept) and index counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r  <= IDLE;
      len_q_r  <= {(ADDR_BITS+1){1'b0}};
      bias_q_r <= {DATA_W{1'b0}};
      rd_idx_r <= {ADDR_BITS{1'b0}};
      wr_idx_r <= {ADDR_BITS{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        len_q_r  <= (len > DEPTH) ? DEPTH : len;
        bias_q_r <= bias;
        rd_idx_r <= {ADDR_BITS{1'b0}};
        wr_idx_r <= {ADDR_BITS{1'b0}};
      end else begin
        if (rd_issue_s) begin
          rd_idx_r <= rd_idx_r + IDX_ONE;
        end
        if (v1_s) begin
          wr_idx_r <= wr_idx_r + IDX_ONE;
        end
      end
    end
  end

  add_bias_pipe #(
    .ADDR_BITS (ADDR_BITS)
  ) u_pipe (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .rd_issue  (rd_issue_s),
    .rd_data   (in_r_q0),
    .bias      (bias_q_r),
    .wr_addr   (wr_idx_r),
    .v1        (v1_s),
    .wr_valid  (wr_valid_s),
    .wr_addr_q (out_r_address0),
    .wr_data   (out_r_d0)
  );

  assign in_r_ce0      = rd_issue_s;
  assign in_r_address0 = rd_idx_r;
  assign out_r_ce0     = wr_valid_s;
  assign out_r_we0     = wr_valid_s;
  assign ap_ready      = last_rd_s;
  assign ap_done       = (state_r == DONE);
  assign ap_idle       = (state_r == IDLE);

endmodule

// File: tb/tb_add_bias_kernel.sv
// Randomized and directed bench for add_bias_kernel against a cycle-level expectation model.
module tb_add_bias_kernel;

  localparam int AB = 6;
  localparam int DEP = 64;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, ap_ready;
  logic [AB:0]   len = '0;
  logic [31:0]   bias = '0;
  logic [AB-1:0] in_r_address0, out_r_address0;
  logic          in_r_ce0, out_r_ce0, out_r_we0;
  logic [31:0]   in_r_q0 = '0;
  logic [31:0]   out_r_d0;

  add_bias_kernel #(.ADDR_BITS(AB)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .len(len), .bias(bias),
    .in_r_address0(in_r_address0), .in_r_ce0(in_r_ce0), .in_r_q0(in_r_q0),
    .out_r_address0(out_r_address0), .out_r_ce0(out_r_ce0), .out_r_we0(out_r_we0),
    .out_r_d0(out_r_d0)
  );

  always #5 ap_clk = ~ap_clk;

  logic [31:0] mem [0:DEP-1];
  int cyc = 0;
  int t0 = 0;
  int n_vec = 0;
  int n_err = 0;
  int we_err = 0;
  int rd_cyc_q[$];
  int rd_addr_q[$];
  int wr_cyc_q[$];
  int wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int ready_q[$];
  int done_q[$];
  logic idle_log [0:255];

  // Input memory with one-cycle read latency; cycle counter.
  always @(posedge ap_clk) begin
    cyc <= cyc + 1;
    if (in_r_ce0) in_r_q0 <= mem[in_r_address0];
  end

  // Observe port activity mid-cycle, indexed relative to the start cycle.
  always @(negedge ap_clk) begin
    int rel;
    rel = cyc - t0;
    if (in_r_ce0) begin rd_cyc_q.push_back(rel); rd_addr_q.push_back(int'(in_r_address0)); end
    if (out_r_ce0) begin
      wr_cyc_q.push_back(rel); wr_addr_q.push_back(int'(out_r_address0)); wr_data_q.push_back(out_r_d0);
    end
    if (out_r_we0 !== out_r_ce0) we_err++;
    if (ap_ready) ready_q.push_back(rel);
    if (ap_done) done_q.push_back(rel);
    if (rel >= 0 && rel < 256) idle_log[rel] = ap_idle;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rd_cyc_q.delete(); rd_addr_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete();
    wr_data_q.delete(); ready_q.delete(); done_q.delete();
    for (int i = 0; i < 256; i++) idle_log[i] = 1'bx;
  endtask

  // Assert start for cycle 0 (relative), with len/bias presented alongside.
  task automatic begin_run(input int l, input logic [31:0] b);
    @(posedge ap_clk); #2;
    clear_log();
    t0 = cyc; len = 7'(l); bias = b; ap_start = 1'b1;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_q.size() < n && k < 300) begin @(negedge ap_clk); k++; end
    check_eq("done_timeout", 64'(done_q.size() >= n), 64'd1);
  endtask

  // Expected behaviour of a single run: N = min(len, depth) words.
  task automatic check_run(input int l, input logic [31:0] b);
    int n, dc;
    n = (l > DEP) ? DEP : l;
    dc = (n == 0) ? 1 : n + 3;
    check_eq("done_cycle", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'(dc));
    check_eq("done_count", 64'(done_q.size()), 64'd1);
    check_eq("idle_after_done", 64'(idle_log[dc + 1]), 64'd1);
    check_eq("idle_at_done", 64'(idle_log[dc]), 64'd0);
    check_eq("ready_count", 64'(ready_q.size()), (n == 0) ? 64'd0 : 64'd1);
    if (ready_q.size() > 0) check_eq("ready_cycle", 64'(ready_q[0]), 64'(n));
    check_eq("read_count", 64'(rd_cyc_q.size()), 64'(n));
    check_eq("write_count", 64'(wr_cyc_q.size()), 64'(n));
    for (int i = 0; i < n && i < rd_cyc_q.size(); i++) begin
      check_eq("read_cycle", 64'(rd_cyc_q[i]), 64'(i + 1));
      check_eq("read_addr", 64'(rd_addr_q[i]), 64'(i));
    end
    for (int i = 0; i < n && i < wr_cyc_q.size(); i++) begin
      logic [31:0] e;
      e = mem[i] + b;
      check_eq("write_cycle", 64'(wr_cyc_q[i]), 64'(i + 3));
      check_eq("write_addr", 64'(wr_addr_q[i]), 64'(i));
      check_eq("write_data", 64'(wr_data_q[i]), 64'(e));
    end
  endtask

  task automatic simple_run(input int l, input logic [31:0] b);
    begin_run(l, b);
    @(posedge ap_clk); #2; ap_start = 1'b0;
    wait_done(1);
    repeat (2) @(negedge ap_clk);
    check_run(l, b);
  endtask

  task automatic fill_identity();
    for (int i = 0; i < DEP; i++) mem[i] = 32'(i);
  endtask

  initial begin
    int l;
    logic [31:0] b;
    fill_identity();
    #3;
    check_eq("rst_idle", 64'(ap_idle), 64'd1);
    check_eq("rst_strobes", 64'({in_r_ce0, out_r_ce0, out_r_we0, ap_ready, ap_done}), 64'd0);
    @(negedge ap_clk); ap_rst_n = 1'b1;

    simple_run(4, 32'd1);
    simple_run(0, 32'd5);
    simple_run(100, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of cycle 4 of a len=8 run.
    begin_run(8, 32'd3);
    @(posedge ap_clk); #2; ap_start = 1'b0;
    repeat (3) @(posedge ap_clk);
    #4; ap_rst_n = 1'b0;
    #1;
    check_eq("midrst_strobes", 64'({in_r_ce0, out_r_ce0, out_r_we0, ap_ready, ap_done}), 64'd0);
    check_eq("midrst_idle", 64'(ap_idle), 64'd1);
    @(negedge ap_clk); ap_rst_n = 1'b1;
    simple_run(2, 32'h10);

    // ap_start held high across two back-to-back runs.
    begin_run(2, 32'd9);
    wait_done(2);
    ap_start = 1'b0;
    repeat (2) @(negedge ap_clk);
    check_eq("held_done0", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd5);
    check_eq("held_done1", 64'(done_q.size() > 1 ? done_q[1] : -1), 64'd11);
    check_eq("held_idle6", 64'(idle_log[6]), 64'd1);
    check_eq("held_writes", 64'(wr_cyc_q.size()), 64'd4);
    if (wr_cyc_q.size() == 4) begin
      check_eq("held_wr2_cycle", 64'(wr_cyc_q[2]), 64'd9);
      check_eq("held_wr3_addr", 64'(wr_addr_q[3]), 64'd1);
      check_eq("held_wr3_data", 64'(wr_data_q[3]), 64'd10);
    end
    check_eq("held_ready1", 64'(ready_q.size() > 1 ? ready_q[1] : -1), 64'd8);

    // len/bias changed mid-run must not affect the run.
    begin_run(4, 32'd0);
    @(posedge ap_clk); #2; ap_start = 1'b0;
    @(posedge ap_clk); #2; len = 7'd1; bias = 32'd7;
    wait_done(1);
    repeat (2) @(negedge ap_clk);
    check_run(4, 32'd0);

    // Randomized runs over random memory contents, lengths and biases.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEP; i++) mem[i] = $urandom;
      l = (r == 0) ? 64 : (r == 1) ? 1 : (r == 2) ? 65 : int'($urandom_range(0, 127));
      b = $urandom;
      simple_run(l, b);
    end

    check_eq("we_equals_ce", 64'(we_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
